// File: rtl/mux4_rr_arbiter_if.sv
// mux4_rr_arbiter_if: requester and output channel bundle for the 4:1 round-robin arbiter
interface mux4_rr_arbiter_if #(parameter int W = 4);
    logic [3:0]   in_valid;
    logic [3:0]   in_last;
    logic [3:0]   in_ready;
    logic [W-1:0] d0, d1, d2, d3;
    logic         out_valid;
    logic [W-1:0] out_data;
    logic         out_last;
    logic [1:0]   out_sel;
    logic         out_ready;
    modport master (
        output in_valid, in_last, d0, d1, d2, d3, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_sel
    );
    modport slave (
        input  in_valid, in_last, d0, d1, d2, d3, out_ready,
        output in_ready, out_valid, out_data, out_last, out_sel
    );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter: round-robin 4:1 stream arbiter with registered output; MUX4_ARB_LOCK_EN adds packet lock
module mux4_rr_arbiter #(parameter int W = 4) (
    input  logic             clk,
    input  logic             rst_n,
    mux4_rr_arbiter_if.slave bus
);
    logic         out_valid_q, out_valid_d;
    logic [W-1:0] out_data_q, out_data_d;
    logic         out_last_q, out_last_d;
    logic [1:0]   out_sel_q, out_sel_d;
    logic [1:0]   ptr_q, ptr_d;
    logic [3:0]   elig;
    logic [1:0]   win, idx;
    logic         found, accept, grant;

`ifdef MUX4_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_t;
    lock_t lock_q, lock_d;
    assign elig = (lock_q == LOCKED) ? bus.in_valid & (4'b1 << ptr_q) : bus.in_valid;
`else
    assign elig = bus.in_valid;
`endif

    assign accept = !out_valid_q || bus.out_ready;
    assign grant  = accept && found;
    assign bus.in_ready = (grant && rst_n) ? 4'b1 << win : 4'b0000;

    // first eligible requester scanning from the one after the last grant
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            idx = ptr_q + 2'(k);
            if (!found && elig[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
    end

    // output stage and pointer: load on grant, bubble on empty accept, hold otherwise
    always_comb begin
        out_valid_d = accept ? found : out_valid_q;
        out_data_d  = out_data_q;
        out_last_d  = out_last_q;
        out_sel_d   = out_sel_q;
        ptr_d       = ptr_q;
        if (grant) begin
            out_data_d = win == 2'd0 ? bus.d0 : win == 2'd1 ? bus.d1 : win == 2'd2 ? bus.d2 : bus.d3;
            out_last_d = bus.in_last[win];
            out_sel_d  = win;
            ptr_d      = win;
        end
    end

    // state registers with asynchronous clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            out_sel_q   <= 2'd0;
            ptr_q       <= 2'd3;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_last_q  <= out_last_d;
            out_sel_q   <= out_sel_d;
            ptr_q       <= ptr_d;
        end
    end

`ifdef MUX4_ARB_LOCK_EN
    // lock on a non-last beat, release when the locked requester sends its last beat
    always_comb begin
        lock_d = lock_q;
        if (grant) lock_d = bus.in_last[win] ? IDLE : LOCKED;
    end

    // lock state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lock_q <= IDLE;
        else        lock_q <= lock_d;
    end
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_last  = out_last_q;
    assign bus.out_sel   = out_sel_q;
endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter: directed-vector bench for mux4_rr_arbiter
module tb_mux4_rr_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int beat;
    logic rdy0;

    mux4_rr_arbiter_if #(.W(4)) bus();
    mux4_rr_arbiter #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        bus.in_valid  = 4'b1111;
        bus.in_last   = 4'b0000;
        bus.d0 = 4'ha; bus.d1 = 4'hb; bus.d2 = 4'hc; bus.d3 = 4'hd;
        bus.out_ready = 1'b1;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 0);
        check("rst_out_data", 32'(bus.out_data), 0);
        check("rst_out_sel", 32'(bus.out_sel), 0);
        check("rst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        // full rotation 0,1,2,3,0
        for (int i = 0; i < 5; i++) begin
            check("rot_in_ready", 32'(bus.in_ready), 32'(1 << (i % 4)));
            edge_step();
            check("rot_out_valid", 32'(bus.out_valid), 1);
            check("rot_out_sel", 32'(bus.out_sel), 32'(i % 4));
            check("rot_out_data", 32'(bus.out_data), 32'(4'ha + 4'(i % 4)));
        end
        // load 'hb then stall three cycles
        check("bp_load_ready", 32'(bus.in_ready), 32'b0010);
        edge_step();
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_in_ready", 32'(bus.in_ready), 0);
            edge_step();
            check("bp_out_data", 32'(bus.out_data), 32'hb);
            check("bp_out_sel", 32'(bus.out_sel), 1);
            check("bp_out_valid", 32'(bus.out_valid), 1);
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_resume_ready", 32'(bus.in_ready), 32'b0100);
        edge_step();
        check("bp_resume_data", 32'(bus.out_data), 32'hc);
        check("bp_resume_valid", 32'(bus.out_valid), 1);
        // sparse: only requester 2
        bus.in_valid = 4'b0100;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("sp2_in_ready", 32'(bus.in_ready), 32'b0100);
            edge_step();
            check("sp2_out_sel", 32'(bus.out_sel), 2);
        end
        bus.in_valid = 4'b0101;
        for (int i = 0; i < 4; i++) begin
            edge_step();
            check("sp02_out_sel", 32'(bus.out_sel), (i % 2 == 0) ? 32'd0 : 32'd2);
        end
        // packet from requester 0 (last=0,0,1) against always-valid requester 1
        beat = 0;
        bus.in_last[1] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = {2'b00, 1'b1, beat < 3};
            bus.in_last[0] = (beat == 2);
            bus.d0 = 4'h5 + 4'(beat);
            #1;
            rdy0 = bus.in_ready[0];
            edge_step();
            if (rdy0) beat++;
`ifdef MUX4_ARB_LOCK_EN
            check("lock_out_sel", 32'(bus.out_sel), (i < 3) ? 32'd0 : 32'd1);
`else
            check("nolock_out_sel", 32'(bus.out_sel), (i % 2 == 0) ? 32'd0 : 32'd1);
`endif
        end
        check("pkt_beats_sent", 32'(beat), 3);
        // mid-stream reset with a stalled output beat
        bus.in_valid = 4'b1111;
        bus.in_last  = 4'b0000;
        bus.d0 = 4'ha;
        bus.out_ready = 1'b0;
        #1;
        check("mrst_pre_valid", 32'(bus.out_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mrst_out_valid", 32'(bus.out_valid), 0);
        check("mrst_in_ready", 32'(bus.in_ready), 0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check("mrst_first_ready", 32'(bus.in_ready), 32'b0001);
        edge_step();
        check("mrst_first_sel", 32'(bus.out_sel), 0);
        check("mrst_first_data", 32'(bus.out_data), 32'ha);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mux4_rr_arbiter.md
# mux4_rr_arbiter

- Round-robin arbiter and sequencer for the 4:1 mux datapath: shares one W-bit output channel among four valid/ready requesters.
- Each cycle it picks a winner, drives the mux select and captures the selected data into a registered output stage with one-cycle latency.
- Sits between four producer streams and a single downstream consumer.
- Optional packet lock keeps the grant on one requester until it sends its last beat.

## Interface

- W, 4, data width of each requester and of the output.

- clk  input  1  clock; all flops on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  4  per-requester valid; bit i belongs to requester i.
- in_last  input  4  per-requester end-of-packet flag, qualified by in_valid.
- d0, d1, d2, d3  input  W  requester data.
- in_ready  output  4  per-requester ready, one-hot or zero, combinational.
- out_valid  output  1  output beat valid.
- out_data  output  W  output beat data.
- out_last  output  1  in_last of the winning beat.
- out_sel  output  2  index of the requester that supplied the current output beat.
- out_ready  input  1  downstream ready.

## Operation

**Definitions**
- accept = !out_valid || out_ready.
- ptr[1:0] = last granted index.
- Scan order for the winner: ptr+1, ptr+2, ptr+3, ptr (mod 4). The first index with in_valid=1 wins.

**Transfer rules**
- accept=1 and any eligible in_valid: in_ready[winner]=1, all other in_ready bits 0.
- On the next edge: out_data<=d_winner, out_sel<=winner, out_last<=in_last[winner], out_valid<=1, ptr<=winner.
- accept=1 and no eligible valid: in_ready=0000, out_valid<=0. out_data, out_sel and out_last hold.
- accept=0: in_ready=0000; out_valid, out_data, out_sel, out_last and ptr hold, stable until out_ready=1.

**Handshake**
- An input beat transfers when in_valid[i] && in_ready[i].
- An output beat transfers when out_valid && out_ready.
- Requesters must not derive in_valid from in_ready, because in_ready depends combinationally on in_valid and out_ready.

**Fairness and throughput**
- Sustained throughput is one beat per cycle with out_ready held at 1.
- A continuously valid requester waits at most 3 grants.

**State machine** (lock state, used only with MUX4_ARB_LOCK_EN)
- IDLE: all requesters eligible.
- IDLE -> LOCKED: an input beat transfers with in_last=0.
- LOCKED: only requester ptr is eligible. If it is not valid, the result is a bubble: out_valid<=0 when accepted, and others are still not granted.
- LOCKED -> IDLE: a beat from requester ptr transfers with in_last=1.

## Timing

**Reset values**
- out_valid=0, out_data=0, out_sel=0, out_last=0, ptr=3, lock state IDLE.
- in_ready=0000 while rst_n=0.

**Reset behaviour**
- Assertion clears all flops immediately, independent of clk.
- Reset mid-beat discards the pending output beat; no replay.
- After release, the first grant goes to requester 0 if it is valid.

**Latency and timing boundaries**
- Latency is 1 cycle from input transfer to out_valid.
- Simultaneous out_ready=1 and a new winner: the old beat leaves and the new beat loads on the same edge, with no bubble.
- ptr wraps 3->0.
- Only one requester valid: it is granted every accepted cycle.

## Configuration

**MUX4_ARB_LOCK_EN defined**
- The IDLE/LOCKED state machine is active.
- Packets from one requester are never interleaved with beats from others.

**Not defined**
- Every beat is arbitrated independently.
- in_last is passed through to out_last only.
- No lock flop exists.

## Test plan

- **Reset:** rst_n=0 between edges with in_valid=1111 -> out_valid=0, out_data=0, in_ready=0000 immediately.
- **Full rotation:** in_valid=1111, d0..d3='ha,'hb,'hc,'hd, out_ready=1 -> out_data a,b,c,d,a on consecutive cycles; out_sel 0,1,2,3,0; in_ready 0001,0010,0100,1000.
- **Backpressure:** output holds 'hb with out_ready=0 for 3 cycles -> out_data='hb, out_sel=1 and in_ready=0000 throughout. Then out_ready=1 -> the next beat is 'hc with no bubble.
- **Sparse requesters:** only in_valid[2] for 3 cycles -> out_sel=2 each cycle. Then in_valid=0101 -> out_sel alternates 0,2,0,2.
- **Lock:** requester 0 sends 3 beats with last=0,0,1 while requester 1 is valid. With MUX4_ARB_LOCK_EN -> out_sel 0,0,0,1. Without it -> out_sel 0,1,0,1,0.
- **Mid-stream reset:** pulse rst_n low while out_valid=1 and out_ready=0 -> out_valid drops asynchronously. After release with in_valid=1111, the first out_sel is 0.
